// File: rtl/mips_stim_seq.sv
// Loadable instruction stimulus sequencer for the mips core: core reset, issue, drain.
// Optional watchdog on looping runs is enabled with `define MIPS_STIM_WDOG_EN.
module mips_stim_seq #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned HOLD_W       = 4,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned CNT_W        = 16
`ifdef MIPS_STIM_WDOG_EN
  , parameter int unsigned WDOG_LIMIT = 256
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_en,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [DATA_W-1:0]          load_instr,
  input  logic [HOLD_W-1:0]          load_hold,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       start,
  input  logic                       loop_en,
  input  logic                       stop,
  input  logic                       regwrite_in,
  output logic                       core_reset,
  output logic [DATA_W-1:0]          instr,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic [CNT_W-1:0]           wb_count,
  output logic [CNT_W-1:0]           cycle_count
`ifdef MIPS_STIM_WDOG_EN
  , output logic                     wdog_trip
`endif
);

  localparam int unsigned IW     = $clog2(DEPTH);
  localparam int unsigned LW     = IW + 1;
  localparam int unsigned PH_MAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PW     = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_RESET_CORE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                core_reset_q, core_reset_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [IW-1:0]       idx_q, idx_d, nxt;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [PW-1:0]       ph_q, ph_d;
  logic                loop_q, loop_d, stop_q, stop_d;
  logic [LW-1:0]       len_q, len_d;
  logic [CNT_W-1:0]    wb_q, wb_d, cyc_q, cyc_d;
  logic                run, last, stop_any, wd_hit;

  logic [DATA_W-1:0]   mem_instr [DEPTH];
  logic [HOLD_W-1:0]   mem_hold  [DEPTH];

`ifdef MIPS_STIM_WDOG_EN
  localparam int unsigned WDW = $clog2(WDOG_LIMIT + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           trip_q, trip_d;
  assign wdog_trip = trip_q;
`endif

  always_ff @(posedge clk) begin
    if (load_en && !busy_q) begin
      mem_instr[load_addr] <= load_instr;
      mem_hold[load_addr]  <= load_hold;
    end
  end

  assign nxt  = idx_q + 1'b1;
  assign last = (LW'(idx_q) + 1'b1) >= len_q;
  assign run  = (state_q == S_ISSUE) || (state_q == S_DRAIN);

  always_comb begin
    state_d      = state_q;
    core_reset_d = core_reset_q;
    instr_d      = instr_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    ph_d         = ph_q;
    loop_d       = loop_q;
    len_d        = len_q;
    stop_d       = stop_q;
    wb_d         = wb_q;
    cyc_d        = cyc_q;
    wd_hit       = 1'b0;
`ifdef MIPS_STIM_WDOG_EN
    wd_d   = wd_q;
    trip_d = trip_q;
    if (state_q == S_ISSUE) begin
      wd_hit = loop_q && !regwrite_in && (wd_q == WDW'(WDOG_LIMIT - 1));
      if (regwrite_in)                   wd_d = '0;
      else if (wd_q != WDW'(WDOG_LIMIT)) wd_d = wd_q + 1'b1;
    end
    if (wd_hit) begin
      trip_d = 1'b1;
      stop_d = 1'b1;
    end
`endif
    if (run && regwrite_in && (wb_q != '1)) wb_d = wb_q + 1'b1;
    if (run && (cyc_q != '1))               cyc_d = cyc_q + 1'b1;
    stop_any = stop_q || stop || wd_hit;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          wb_d   = '0;
          cyc_d  = '0;
          idx_d  = '0;
          loop_d = loop_en;
          len_d  = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
          stop_d = 1'b0;
`ifdef MIPS_STIM_WDOG_EN
          wd_d   = '0;
          trip_d = 1'b0;
`endif
          if (prog_len == '0) begin
            state_d      = S_DONE;
            core_reset_d = 1'b0;
            instr_d      = NOP_WORD;
          end else begin
            state_d      = S_RESET_CORE;
            core_reset_d = 1'b1;
            instr_d      = NOP_WORD;
            ph_d         = PW'(RST_CYCLES - 1);
          end
        end
      end
      S_RESET_CORE: begin
        if (stop) begin
          state_d      = S_DRAIN;
          core_reset_d = 1'b0;
          ph_d         = PW'(DRAIN_CYCLES - 1);
        end else if (ph_q == '0) begin
          state_d      = S_ISSUE;
          core_reset_d = 1'b0;
          instr_d      = mem_instr[0];
          hold_d       = mem_hold[0];
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_ISSUE: begin
        if (stop) stop_d = 1'b1;
        // Entry boundary: a pending stop beats both advance and wrap.
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (!stop_any && !last) begin
          idx_d   = nxt;
          instr_d = mem_instr[nxt];
          hold_d  = mem_hold[nxt];
        end else if (!stop_any && loop_q) begin
          idx_d   = '0;
          instr_d = mem_instr[0];
          hold_d  = mem_hold[0];
        end else begin
          state_d = S_DRAIN;
          instr_d = NOP_WORD;
          ph_d    = PW'(DRAIN_CYCLES - 1);
        end
      end
      S_DRAIN: begin
        if (ph_q == '0) state_d = S_DONE;
        else            ph_d    = ph_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RESET_CORE) || (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      core_reset_q <= 1'b1;
      instr_q      <= NOP_WORD;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      idx_q        <= '0;
      hold_q       <= '0;
      ph_q         <= '0;
      loop_q       <= 1'b0;
      len_q        <= '0;
      stop_q       <= 1'b0;
      wb_q         <= '0;
      cyc_q        <= '0;
`ifdef MIPS_STIM_WDOG_EN
      wd_q         <= '0;
      trip_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      instr_q      <= instr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      ph_q         <= ph_d;
      loop_q       <= loop_d;
      len_q        <= len_d;
      stop_q       <= stop_d;
      wb_q         <= wb_d;
      cyc_q        <= cyc_d;
`ifdef MIPS_STIM_WDOG_EN
      wd_q         <= wd_d;
      trip_q       <= trip_d;
`endif
    end
  end

  assign core_reset  = core_reset_q;
  assign instr       = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign idx         = idx_q;
  assign wb_count    = wb_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_mips_stim_seq.sv
// Self-checking bench for mips_stim_seq: per-cycle trace predicted from the program contents.
module tb_mips_stim_seq;

  localparam int RST = 2;
  localparam int DRN = 5;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, load_en, start, loop_en, stop, regwrite_in;
  logic [3:0]  load_addr, load_hold, idx;
  logic [31:0] load_instr, instr;
  logic [4:0]  prog_len;
  logic        core_reset, busy, done;
  logic [15:0] wb_count, cycle_count;
`ifdef MIPS_STIM_WDOG_EN
  logic        wdog_trip;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic        cr;
    logic [31:0] ins;
    logic [3:0]  idx;
    logic        busy;
    logic        run;
    logic        iss;
  } cyc_t;

  cyc_t        exp_q[$];
  logic [31:0] prog_w [16];
  logic [3:0]  prog_h [16];

  always #5 clk = ~clk;

  mips_stim_seq #(
    .DATA_W(32), .DEPTH(16), .HOLD_W(4), .RST_CYCLES(RST), .DRAIN_CYCLES(DRN),
    .NOP_WORD(NOP), .CNT_W(16)
`ifdef MIPS_STIM_WDOG_EN
    , .WDOG_LIMIT(8)
`endif
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_instr(load_instr), .load_hold(load_hold), .prog_len(prog_len),
    .start(start), .loop_en(loop_en), .stop(stop), .regwrite_in(regwrite_in),
    .core_reset(core_reset), .instr(instr), .busy(busy), .done(done), .idx(idx),
    .wb_count(wb_count), .cycle_count(cycle_count)
`ifdef MIPS_STIM_WDOG_EN
    , .wdog_trip(wdog_trip)
`endif
  );

  // Expected trace of one run, one element per cycle after the start edge.
  task automatic build_model(input int len, input bit lp, input int stop_at);
    cyc_t c;
    int   n = 0;
    int   e = 0;
    exp_q.delete();
    for (int i = 0; i < RST; i++) begin
      c = '{cr: 1'b1, ins: NOP, idx: 4'd0, busy: 1'b1, run: 1'b0, iss: 1'b0};
      exp_q.push_back(c);
    end
    while (n < 4000) begin
      for (int r = 0; r <= int'(prog_h[e]); r++) begin
        c = '{cr: 1'b0, ins: prog_w[e], idx: 4'(e), busy: 1'b1, run: 1'b1, iss: 1'b1};
        exp_q.push_back(c);
        n++;
      end
      if (stop_at >= 0 && stop_at < n) break;
      if (e == len - 1) begin
        if (!lp) break;
        e = 0;
      end else begin
        e++;
      end
    end
    for (int i = 0; i < DRN; i++) begin
      c = '{cr: 1'b0, ins: NOP, idx: 4'(e), busy: 1'b1, run: 1'b1, iss: 1'b0};
      exp_q.push_back(c);
    end
  endtask

  task automatic load_slot(input int a, input logic [31:0] w, input logic [3:0] h);
    load_en = 1'b1; load_addr = 4'(a); load_instr = w; load_hold = h;
    prog_w[a] = w; prog_h[a] = h;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // rw_mode: 0 low, 1 high, 2 random. co_load writes a slot on the start edge.
  task automatic run_prog(input string name, input int len, input bit lp, input int stop_at,
                          input int rw_mode, input bit co_load);
    int   wb_exp = 0;
    int   cyc_exp = 0;
    int   icnt = 0;
    cyc_t e;
    if (co_load) begin
      load_en = 1'b1; load_addr = 4'($urandom_range(0, len - 1));
      load_instr = $urandom; load_hold = 4'($urandom_range(0, 2));
      prog_w[load_addr] = load_instr; prog_h[load_addr] = load_hold;
    end
    build_model(len, lp, stop_at);
    prog_len = 5'(len); loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0; loop_en = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      n_checks++;
      if ({core_reset, instr, idx, busy, done} !== {e.cr, e.ins, e.idx, e.busy, 1'b0}) begin
        n_fails++;
        $display("FAIL %s cyc%0d: cr/instr/idx/busy/done got %b %h %0d %b %b exp %b %h %0d %b 0",
                 name, i, core_reset, instr, idx, busy, done, e.cr, e.ins, e.idx, e.busy);
      end
      regwrite_in = (rw_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rw_mode);
      stop = e.iss && (icnt == stop_at);
      if (e.iss) icnt++;
      if (e.run && regwrite_in) wb_exp++;
      if (e.run) cyc_exp++;
      @(negedge clk);
    end
    regwrite_in = 1'b0; stop = 1'b0;
    n_checks++;
    if ({done, busy, core_reset, instr} !== {1'b1, 1'b0, 1'b0, NOP}) begin
      n_fails++;
      $display("FAIL %s end: done/busy/cr/instr got %b %b %b %h exp 1 0 0 %h",
               name, done, busy, core_reset, instr, NOP);
    end
    n_checks++;
    if (wb_count !== 16'(wb_exp) || cycle_count !== 16'(cyc_exp)) begin
      n_fails++;
      $display("FAIL %s counts: wb/cyc got %0d %0d exp %0d %0d",
               name, wb_count, cycle_count, wb_exp, cyc_exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({core_reset, instr, busy, done, idx, wb_count, cycle_count} !==
        {1'b1, NOP, 1'b0, 1'b0, 4'd0, 16'd0, 16'd0}) begin
      n_fails++;
      $display("FAIL %s: cr=%b instr=%h busy=%b done=%b idx=%0d wb=%0d cyc=%0d exp 1 %h 0 0 0 0 0",
               name, core_reset, instr, busy, done, idx, wb_count, cycle_count, NOP);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_hold");
  endtask

  task automatic test_basic();
    load_slot(0, 32'h2002_0001, 4'd0);
    load_slot(1, 32'h2003_0002, 4'd0);
    load_slot(2, 32'h0800_0003, 4'd0);
    run_prog("basic", 3, 1'b0, -1, 2, 1'b0);
    n_checks++;
    if (cycle_count !== 16'd8) begin
      n_fails++;
      $display("FAIL basic_cycles: got %0d exp 8", cycle_count);
    end
  endtask

  task automatic test_hold();
    load_slot(0, 32'hAAAA_0000, 4'd3);
    load_slot(1, 32'hBBBB_0001, 4'd0);
    run_prog("hold", 2, 1'b0, -1, 2, 1'b0);
  endtask

  task automatic test_loop_stop();
    run_prog("loop_stop", 2, 1'b1, 7, 1, 1'b0);
    n_checks++;
    if (wb_count !== cycle_count) begin
      n_fails++;
      $display("FAIL loop_stop_wb_eq: wb=%0d cyc=%0d", wb_count, cycle_count);
    end
  endtask

  task automatic test_reset_mid();
    load_slot(0, 32'h1111_0000, 4'd0);
    load_slot(1, 32'h2222_0001, 4'd0);
    prog_len = 5'd2; loop_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; loop_en = 1'b0;
    repeat (RST + 1) @(negedge clk);
    n_checks++;
    if (idx !== 4'd1 || instr !== 32'h2222_0001) begin
      n_fails++;
      $display("FAIL mid_issue: idx=%0d instr=%h exp 1 22220001", idx, instr);
    end
    regwrite_in = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    regwrite_in = 1'b0;
    check_idle_outputs("reset_mid");
    reset = 1'b0;
    @(negedge clk);
    run_prog("replay", 2, 1'b0, -1, 2, 1'b0);
  endtask

  task automatic test_load_busy();
    int waited = 0;
    prog_len = 5'd2; loop_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b1; load_addr = 4'd0; load_instr = 32'hDEAD_BEEF; load_hold = 4'd7;
    @(negedge clk);
    load_en = 1'b0;
    while (!done && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (!done) begin
      n_fails++;
      $display("FAIL busy_run_timeout: done=%b after %0d cycles", done, waited);
    end
    run_prog("after_busy_load", 2, 1'b0, -1, 2, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    prog_len = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cycle_count !== 16'd0) begin
        n_fails++;
        $display("FAIL len0 cyc%0d: done=%b busy=%b cyc=%0d exp 1 0 0", i, done, busy, cycle_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int len, st;
    bit lp;
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 16);
      lp  = 1'($urandom_range(0, 1));
      st  = lp ? $urandom_range(0, 40) : ($urandom_range(0, 1) ? $urandom_range(0, 20) : -1);
      for (int s = 0; s < len; s++) load_slot(s, $urandom, 4'($urandom_range(0, 3)));
      run_prog($sformatf("random%0d", it), len, lp, st, 2, 1'b1);
    end
  endtask

`ifdef MIPS_STIM_WDOG_EN
  task automatic test_wdog();
    load_slot(0, 32'h3333_0000, 4'd0);
    load_slot(1, 32'h4444_0001, 4'd1);
    run_prog("wdog", 2, 1'b1, 7, 0, 1'b0);
    n_checks++;
    if (wdog_trip !== 1'b1) begin
      n_fails++;
      $display("FAIL wdog_trip_set: got %b exp 1", wdog_trip);
    end
    run_prog("wdog_noloop", 2, 1'b0, -1, 0, 1'b0);
    n_checks++;
    if (wdog_trip !== 1'b0) begin
      n_fails++;
      $display("FAIL wdog_trip_clear: got %b exp 0", wdog_trip);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_instr = '0; load_hold = '0;
    prog_len = '0; start = 1'b0; loop_en = 1'b0; stop = 1'b0; regwrite_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hold();
    test_loop_stop();
    test_reset_mid();
    test_load_busy();
    test_random();
`ifdef MIPS_STIM_WDOG_EN
    test_wdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mips_stim_seq.md
Name: mips_stim_seq

Overview:
Synthesizable, loadable instruction stimulus sequencer for the mips core. It replaces hand-timed instruction pokes with a programmable sequence:
- holds up to DEPTH instruction words, each with a per-entry hold count;
- sequences core reset, then issue, then pipeline drain;
- counts write-backs reported by the core;
- can loop the program.

It sits between the bench/host and the core's clk, reset and instr inputs.

Parameters:
DATA_W, 32, instruction width
DEPTH, 16, program slots (power of 2, >=2)
HOLD_W, 4, per-entry hold-count width
RST_CYCLES, 2, cycles core_reset is held high on start (>=1)
DRAIN_CYCLES, 5, NOP cycles after the last entry before done
NOP_WORD, 32'h00000000, word driven when not issuing
CNT_W, 16, width of wb_count and cycle_count

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
load_en  in  1  write one program slot (accepted only when not busy)
load_addr  in  $clog2(DEPTH)  slot index
load_instr  in  DATA_W  instruction word
load_hold  in  HOLD_W  extra cycles to hold this word (0 = 1 cycle)
prog_len  in  $clog2(DEPTH)+1  number of slots to run, 0..DEPTH
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
loop_en  in  1  sampled on start; restart at slot 0 after the last slot
stop  in  1  pulse; abort to DRAIN at the next issue boundary
regwrite_in  in  1  core regWriteW
core_reset  out  1  reset to core
instr  out  DATA_W  instruction to core
busy  out  1  high in RESET_CORE/ISSUE/DRAIN
done  out  1  high in DONE
idx  out  $clog2(DEPTH)  slot currently issued
wb_count  out  CNT_W  regwrite_in pulses counted during the run
cycle_count  out  CNT_W  cycles spent in ISSUE+DRAIN

Behaviour:
- The design has one clock and one reset. Reset is synchronous and active-high; the ports are named clk and reset.
- Reset values:
  - state IDLE, core_reset=1, instr=NOP_WORD, busy=0, done=0, idx=0;
  - wb_count=0, cycle_count=0, hold counter=0, loop flag=0;
  - program memory contents are not reset.
- Reset asserted mid-run returns to IDLE at the next edge; no partial outputs survive.
- All outputs are registered.
- Load: when load_en=1 and busy=0, the slot at load_addr gets {load_instr, load_hold} at the edge. load_en while busy is ignored.
- FSM:
  - IDLE: core_reset=1, instr=NOP_WORD.
    - start with prog_len=0 goes directly to DONE.
    - Otherwise start goes to RESET_CORE; clears the counters, latches loop_en and prog_len, sets idx=0.
  - RESET_CORE: core_reset=1 for exactly RST_CYCLES cycles, then ISSUE. core_reset drops on the same edge that instr takes slot 0.
  - ISSUE: instr=mem[idx] for load_hold+1 cycles. At the end of the hold:
    - if idx<prog_len-1, set idx=idx+1;
    - else if loop flag, set idx=0 (wrap);
    - else go to DRAIN.
  - DRAIN: instr=NOP_WORD for DRAIN_CYCLES cycles, then DONE.
  - DONE: done=1 and core_reset=0; the core keeps running NOPs. start re-enters RESET_CORE. A new program may be loaded here.
- stop:
  - In ISSUE it is latched. At the end of the current entry's hold, the block goes to DRAIN regardless of the loop flag.
  - In RESET_CORE it goes to DRAIN immediately.
  - In other states it is ignored.
- start while busy is ignored.
- wb_count increments on every cycle with regwrite_in=1 while in ISSUE or DRAIN. It saturates at all ones.
- cycle_count increments each ISSUE/DRAIN cycle and also saturates.
- Simultaneous start and load_en in IDLE: the load is written. The run starts from the same edge, so the written slot is visible on the first issue.

Optional Feature:
MIPS_STIM_WDOG_EN:
- Defined: adds parameter WDOG_LIMIT (default 256) and output wdog_trip.
  - In a looping run, if no regwrite_in is seen for WDOG_LIMIT consecutive cycles, wdog_trip is set (sticky until the next start or reset) and the FSM takes the stop path to DRAIN.
  - In a non-looping run the counter runs but never trips.
- Undefined: no watchdog logic and no wdog_trip port; looping runs end only via stop or reset.

Test Plan:
1. Load slots 0..2 = 20020001/20030002/08000003, holds 0, prog_len=3, start, RST_CYCLES=2.
   -> core_reset high 2 cycles, then instr shows the 3 words on consecutive cycles, then 5 cycles of 00000000, then done=1 and cycle_count=8.
2. Slot 0 hold=3, slot 1 hold=0, prog_len=2.
   -> slot 0 word on instr for 4 cycles and slot 1 for 1 cycle; idx goes 0,0,0,0,1.
3. loop_en=1, prog_len=2, regwrite_in tied high, stop pulsed after 7 issue cycles.
   -> idx sequence 0,1,0,1,...; it finishes the current entry, drains, and reaches done. wb_count equals cycle_count.
4. Reset asserted during ISSUE at idx=1.
   -> next cycle: IDLE, core_reset=1, instr=0, counters 0. A fresh start replays from slot 0 with the prior memory contents intact.
5. load_en to slot 0 while busy, then a new run.
   -> the original slot 0 word is issued; the write was ignored. prog_len=0 start -> done=1 on the next cycle, busy never high.
6. (WDOG_EN, WDOG_LIMIT=8) loop run with regwrite_in=0.
   -> wdog_trip=1 after 8 cycles, drain follows, done=1; wdog_trip clears on the next start.
